// File: rtl/write_line_len_req.sv
// write_line_len_req
// Turns frame/line geometry into a stream of AXI write burst requests.
// Each unit is cut into full NOR_BURST_LEN bursts plus one shorter tail burst.
// A request is only raised once the write FIFO holds enough words for it.
// Only one burst is outstanding at a time.
// The unit reloads itself after its tail burst completes, or early on fsync.
module write_line_len_req #(
    parameter int    NOR_BURST_LEN = 200,
    parameter string MODE          = "ONCE",
    parameter int    AXI_DSIZE     = 256,
    parameter int    DSIZE         = 24,
    parameter int    LSIZE         = 9
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [15:0]      vactive,
    input  logic [15:0]      hactive,
    input  logic             fsync,
    input  logic [15:0]      words_avail,
    output logic             burst_req,
    output logic [LSIZE-1:0] burst_len,
    output logic             burst_tail,
    input  logic             burst_ack,
    input  logic             burst_done,
    output logic             unit_done,
    output logic             busy
);

    localparam int               SHIFT      = $clog2(AXI_DSIZE);
    localparam logic [47:0]      WORD_MASK  = 48'(AXI_DSIZE - 1);
    localparam logic [31:0]      NOR_LEN32  = 32'(NOR_BURST_LEN);
    localparam logic [LSIZE-1:0] NOR_LEN_L  = LSIZE'(NOR_BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_REQ,
        S_BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      remaining_q, remaining_d;
    logic             sync_pend_q, sync_pend_d;
    logic             req_d;
    logic [LSIZE-1:0] len_d;
    logic             tail_d;
    logic             unit_done_d;

    logic [31:0]      all_pix_q;
    logic [47:0]      bits;
    logic [31:0]      total_words_q;
    logic [LSIZE-1:0] cur_len;
    logic             is_tail;

    // In LINE mode vactive has no effect; this keeps it referenced.
    logic unused_geom;
    assign unused_geom = ^vactive;

    // Geometry stage 1: pixel count of one unit.
    always_ff @(posedge clock) begin
        if (MODE == "LINE")
            all_pix_q <= {16'd0, hactive};
        else
            all_pix_q <= 32'(vactive) * 32'(hactive);
    end

    assign bits = 48'(all_pix_q) * 48'(DSIZE);

    // Geometry stage 2: bit count rounded up to whole AXI words.
    always_ff @(posedge clock) begin
        total_words_q <= 32'(bits >> SHIFT) + {31'd0, |(bits & WORD_MASK)};
    end

    assign is_tail = (remaining_q <= NOR_LEN32);
    assign cur_len = is_tail ? remaining_q[LSIZE-1:0] : NOR_LEN_L;
    assign busy    = (state_q != S_IDLE);

    // State register and registered request outputs.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            sync_pend_q <= 1'b0;
            burst_req   <= 1'b0;
            burst_len   <= '0;
            burst_tail  <= 1'b0;
            unit_done   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            sync_pend_q <= sync_pend_d;
            burst_req   <= req_d;
            burst_len   <= len_d;
            burst_tail  <= tail_d;
            unit_done   <= unit_done_d;
        end
    end

    // Next-state logic: burst sizing, request handshake and reload handling.
    // A reload to zero words drops back to IDLE, so a zero-length burst is never issued.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        sync_pend_d = sync_pend_q;
        req_d       = burst_req;
        len_d       = burst_len;
        tail_d      = burst_tail;
        unit_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fsync) begin
                    remaining_d = total_words_q;
                    if (total_words_q != 32'd0)
                        state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fsync) begin
                    remaining_d = total_words_q;
                    if (total_words_q == 32'd0)
                        state_d = S_IDLE;
                end else if (32'(words_avail) >= 32'(cur_len)) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    len_d   = cur_len;
                    tail_d  = is_tail;
                end
            end
            S_REQ: begin
                if (fsync)
                    sync_pend_d = 1'b1;
                if (burst_ack) begin
                    req_d   = 1'b0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (burst_done) begin
                    if (sync_pend_q || fsync) begin
                        remaining_d = total_words_q;
                        sync_pend_d = 1'b0;
                        state_d     = (total_words_q != 32'd0) ? S_WAIT : S_IDLE;
                    end else if (burst_tail) begin
                        unit_done_d = 1'b1;
                        remaining_d = total_words_q;
                        state_d     = (total_words_q != 32'd0) ? S_WAIT : S_IDLE;
                    end else begin
                        remaining_d = remaining_q - 32'(burst_len);
                        state_d     = S_WAIT;
                    end
                end else if (fsync) begin
                    sync_pend_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
